// File: rtl/aes_pkg.sv
// Shared AES-128 constants for the iterative key schedule: round count, Rcon, S-box and FSM state type.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ksState_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rcon lookup that returns 0 outside 1..10 so the unused idx=10 path never indexes out of range.
    function automatic logic [7:0] rconFor(input logic [3:0] round);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (round == 4'(i)) r = RCON[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion streaming one round key per accepted handshake.
// Optional round-key store for reverse readout is enabled with `define KEY_SCHEDULE_STORE_EN.
module key_schedule_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
`ifdef KEY_SCHEDULE_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ksState_t     r_state;
    ksState_t     w_nextState;
    logic [127:0] r_roundKey;
    logic [3:0]   r_roundIdx;
    logic         r_rkValid;
    logic         r_done;

    logic         w_handshake;
    logic         w_lastAccept;
    logic         w_load;
    logic         w_advance;
    logic         w_finish;
    logic [31:0]  w_rotWord;
    logic [31:0]  w_subWord;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [127:0] w_nextKey;

    assign w_handshake  = r_rkValid && rk_ready;
    assign w_lastAccept = w_handshake && (r_roundIdx == LAST_IDX);

    assign w_rotWord = {r_roundKey[23:0], r_roundKey[31:24]};

    sub_word u_subWord (
        .i_word (w_rotWord),
        .o_word (w_subWord)
    );

    assign w_w0      = r_roundKey[127:96] ^ w_subWord ^ {rconFor(4'(r_roundIdx + 4'd1)), 24'h0};
    assign w_w1      = r_roundKey[95:64] ^ w_w0;
    assign w_w2      = r_roundKey[63:32] ^ w_w1;
    assign w_w3      = r_roundKey[31:0]  ^ w_w2;
    assign w_nextKey = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start)        w_nextState = RUN;
            RUN:     if (w_lastAccept) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: w_load = start;
            RUN: begin
                w_advance = w_handshake && !w_lastAccept;
                w_finish  = w_lastAccept;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_roundKey <= '0;
            r_roundIdx <= '0;
            r_rkValid  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_roundKey <= key_in;
                r_roundIdx <= '0;
                r_rkValid  <= 1'b1;
            end else if (w_advance) begin
                r_roundKey <= w_nextKey;
                r_roundIdx <= 4'(r_roundIdx + 4'd1);
            end else if (w_finish) begin
                r_rkValid  <= 1'b0;
            end
        end
    end

    assign round_key = r_roundKey;
    assign round_idx = r_roundIdx;
    assign rk_valid  = r_rkValid;
    assign busy      = (r_state == RUN);
    assign done      = r_done;

`ifdef KEY_SCHEDULE_STORE_EN
    logic [127:0] r_store [0:NR];

    // Each key is captured as it is accepted, so the store always holds what the consumer saw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) r_store[i] <= '0;
        end else if (w_handshake && (r_roundIdx <= LAST_IDX)) begin
            r_store[r_roundIdx] <= r_roundKey;
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST_IDX) rd_key = r_store[rd_idx];
    end
`endif

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed self-checking bench for key_schedule_iter (store checks when KEY_SCHEDULE_STORE_EN is defined).
module tb_key_schedule_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
`ifdef KEY_SCHEDULE_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ONES_KEY = {128{1'b1}};
    localparam logic [127:0] ONES_RK1 = 128'he8e9e9e917161616e8e9e9e917161616;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    key_schedule_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
`ifdef KEY_SCHEDULE_STORE_EN
        ,
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
`ifdef KEY_SCHEDULE_STORE_EN
        rd_idx = '0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({rk_valid, busy, done, round_idx, round_key} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: got v=%b b=%b d=%b idx=%0d key=%h, want all 0",
                     rk_valid, busy, done, round_idx, round_key);
        end
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rk_valid, busy, done, round_idx, round_key} !== '0) begin
            failures++;
            $display("[TB] FAIL start_during_reset: got v=%b b=%b idx=%0d key=%h, want all 0",
                     rk_valid, busy, round_idx, round_key);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips_stream();
        @(negedge clk);
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0; key_in = '0;
            checks++;
            if (c <= 11) begin
                if ({rk_valid, busy, done, round_idx, round_key} !==
                    {1'b1, 1'b1, 1'b0, 4'(c - 1), FIPS_RK[c - 1]}) begin
                    failures++;
                    $display("[TB] FAIL fips_stream c%0d: got v=%b b=%b d=%b idx=%0d key=%h, want v=1 b=1 d=0 idx=%0d key=%h",
                             c, rk_valid, busy, done, round_idx, round_key, c - 1, FIPS_RK[c - 1]);
                end
            end else if (c == 12) begin
                if ({rk_valid, busy, done} !== 3'b001) begin
                    failures++;
                    $display("[TB] FAIL fips_done_cycle: got v=%b b=%b d=%b, want v=0 b=0 d=1",
                             rk_valid, busy, done);
                end
            end else begin
                if ({rk_valid, busy, done} !== 3'b000) begin
                    failures++;
                    $display("[TB] FAIL fips_done_pulse: got v=%b b=%b d=%b, want 000",
                             rk_valid, busy, done);
                end
            end
        end
    endtask

`ifdef KEY_SCHEDULE_STORE_EN
    task automatic test_store();
        rd_idx = 4'd10;
        #1;
        checks++;
        if (rd_key !== FIPS_RK[10]) begin
            failures++;
            $display("[TB] FAIL store_idx10: got %h want %h", rd_key, FIPS_RK[10]);
        end
        rd_idx = 4'd0;
        #1;
        checks++;
        if (rd_key !== FIPS_RK[0]) begin
            failures++;
            $display("[TB] FAIL store_idx0: got %h want %h", rd_key, FIPS_RK[0]);
        end
        rd_idx = 4'd15;
        #1;
        checks++;
        if (rd_key !== '0) begin
            failures++;
            $display("[TB] FAIL store_idx15: got %h want 0", rd_key);
        end
        rd_idx = 4'd0;
    endtask
`endif

    task automatic test_backpressure();
        int expIdx = 0;
        int stalls = 0;
        @(negedge clk);
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && expIdx <= 10; cyc++) begin
            checks++;
            if ({rk_valid, round_idx, round_key} !== {1'b1, 4'(expIdx), FIPS_RK[expIdx]}) begin
                failures++;
                $display("[TB] FAIL backpressure cyc%0d: got v=%b idx=%0d key=%h, want v=1 idx=%0d key=%h",
                         cyc, rk_valid, round_idx, round_key, expIdx, FIPS_RK[expIdx]);
            end
            if (expIdx == 4 && stalls < 3) begin
                rk_ready = 1'b0;
                stalls++;
            end else begin
                rk_ready = 1'b1;
                expIdx++;
            end
            @(negedge clk);
        end
        rk_ready = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_done: got d=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int expIdx = 0;
        @(negedge clk);
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && expIdx <= 10; cyc++) begin
            checks++;
            if ({rk_valid, busy, round_idx, round_key} !== {1'b1, 1'b1, 4'(expIdx), FIPS_RK[expIdx]}) begin
                failures++;
                $display("[TB] FAIL start_ignored cyc%0d: got v=%b b=%b idx=%0d key=%h, want idx=%0d key=%h",
                         cyc, rk_valid, busy, round_idx, round_key, expIdx, FIPS_RK[expIdx]);
            end
            if (expIdx == 3) begin
                start = 1'b1; key_in = ONES_KEY;
            end else begin
                start = 1'b0;
            end
            expIdx++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_ignored_done: got d=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int waited = 0;
        @(negedge clk);
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (round_idx !== 4'd6 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (round_idx !== 4'd6) begin
            failures++;
            $display("[TB] FAIL reach_idx6: got idx=%0d want 6", round_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rk_valid, busy, done, round_idx, round_key} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_run_reset: got v=%b b=%b d=%b idx=%0d key=%h, want all 0",
                     rk_valid, busy, done, round_idx, round_key);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; key_in = ONES_KEY;
        @(negedge clk);
        start = 1'b0; key_in = FIPS_KEY;
        checks++;
        if ({rk_valid, busy, round_idx, round_key} !== {1'b1, 1'b1, 4'd0, ONES_KEY}) begin
            failures++;
            $display("[TB] FAIL restart_idx0: got v=%b b=%b idx=%0d key=%h, want idx=0 key=%h",
                     rk_valid, busy, round_idx, round_key, ONES_KEY);
        end
        @(negedge clk);
        checks++;
        if ({rk_valid, round_idx, round_key} !== {1'b1, 4'd1, ONES_RK1}) begin
            failures++;
            $display("[TB] FAIL restart_idx1: got v=%b idx=%0d key=%h, want idx=1 key=%h",
                     rk_valid, round_idx, round_key, ONES_RK1);
        end
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_done_timeout: got d=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; key_in = ONES_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first_done_timeout: got d=%b want 1", done);
        end
        start = 1'b1; key_in = FIPS_KEY;
        @(negedge clk);
        start = 1'b0; key_in = '0;
        checks++;
        if ({rk_valid, busy, done, round_idx, round_key} !== {1'b1, 1'b1, 1'b0, 4'd0, FIPS_KEY}) begin
            failures++;
            $display("[TB] FAIL b2b_restart: got v=%b b=%b d=%b idx=%0d key=%h, want v=1 b=1 d=0 idx=0 key=%h",
                     rk_valid, busy, done, round_idx, round_key, FIPS_KEY);
        end
        @(negedge clk);
        checks++;
        if ({round_idx, round_key} !== {4'd1, FIPS_RK[1]}) begin
            failures++;
            $display("[TB] FAIL b2b_idx1: got idx=%0d key=%h want idx=1 key=%h",
                     round_idx, round_key, FIPS_RK[1]);
        end
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_done_timeout: got d=%b want 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fips_stream();
`ifdef KEY_SCHEDULE_STORE_EN
        test_store();
`endif
        test_backpressure();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
